// File: rtl/rv_trace_pkg.sv
// Shared types for the retire-trace buffer.
//  - state_t      : capture FSM encoding, visible on o_state
//  - trace_body_t : per-retire record minus the timestamp; the stored record
//                   is {ts, trace_body_t}, so the timestamp width can stay a
//                   module parameter of rv_trace_buf
//  - *_LSB        : bit offsets of each field inside trace_body_t
// Build option: RV_TRACE_MEM_EN appends the load/store fields
// {mem_we, mem_re, mem_sel, mem_addr, mem_data} below rd_data.
package rv_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DUMP  = 3'd4
    } state_t;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
`ifdef RV_TRACE_MEM_EN
        logic        mem_we;
        logic        mem_re;
        logic [3:0]  mem_sel;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`endif
    } trace_body_t;

    localparam int BODY_W = $bits(trace_body_t);

`ifdef RV_TRACE_MEM_EN
    localparam int MEM_W = 70;
`else
    localparam int MEM_W = 0;
`endif

    localparam int RD_DATA_LSB = MEM_W;
    localparam int RD_LSB      = MEM_W + 32;
    localparam int RD_WE_BIT   = MEM_W + 37;
    localparam int INSTR_LSB   = MEM_W + 38;
    localparam int PC_LSB      = MEM_W + 70;
    localparam int TS_LSB      = BODY_W;

endpackage

// File: rtl/rv_trace_ram.sv
// Trace record storage: simple dual-port RAM, DEPTH x WIDTH.
//  i_we/i_waddr/i_wdata : write port
//  i_re/i_raddr         : read port; o_rdata updates one cycle after i_re
//                         and holds its value while i_re is low
//  i_rd_clr             : synchronous clear of the read register only
module rv_trace_ram #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 116,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    input  logic             i_rd_clr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // The read register doubles as the stream's holding register.
    always_ff @(posedge i_clk) begin
        if (i_rd_clr) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/rv_trace_buf.sv
// Retire-trace capture buffer. Records {ts, pc, instr, rd_we, rd, rd_data}
// per retired instruction into a circular RAM, stops a programmable number
// of records after a trigger, then streams the frozen records oldest-first.
//  i_clk/i_reset        : clock, synchronous active-high reset
//  i_ret_*              : retire interface (mem fields with RV_TRACE_MEM_EN)
//  i_arm                : clear buffer, start capture
//  i_trig/i_trig_pc_en/i_trig_pc : external trigger and PC-match trigger
//  i_post_cnt           : records kept after the trigger record
//  o_rd_data/o_rd_valid/i_rd_ready : dump stream
//  o_state/o_count/o_wrapped       : status
// Build option: RV_TRACE_MEM_EN adds the i_ret_mem_* ports and fields.
//
// state | meaning
// IDLE  | no capture
// ARMED | recording, waiting for a trigger
// POST  | recording the post-trigger records
// DONE  | frozen, locate oldest record
// DUMP  | streaming records out
module rv_trace_buf
    import rv_trace_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  TS_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int REC_W = TS_W + BODY_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ret_valid,
    input  logic [29:0]      i_ret_pc,
    input  logic [31:0]      i_ret_instr,
    input  logic             i_ret_rd_we,
    input  logic [4:0]       i_ret_rd,
    input  logic [31:0]      i_ret_rd_data,
`ifdef RV_TRACE_MEM_EN
    input  logic             i_ret_mem_we,
    input  logic             i_ret_mem_re,
    input  logic [31:0]      i_ret_mem_addr,
    input  logic [3:0]       i_ret_mem_sel,
    input  logic [31:0]      i_ret_mem_data,
`endif
    input  logic             i_arm,
    input  logic             i_trig,
    input  logic             i_trig_pc_en,
    input  logic [29:0]      i_trig_pc,
    input  logic [AW-1:0]    i_post_cnt,
    output logic [REC_W-1:0] o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [2:0]       o_state,
    output logic [AW:0]      o_count,
    output logic             o_wrapped
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PL_ONE   = AW'(1);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   post_left_q, post_left_d;
    logic            wrapped_q, wrapped_d;
    logic            rd_valid_q, rd_valid_d;
    logic [TS_W-1:0] ts_q;

    logic            trig_hit;
    logic            handshake;
    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    trace_body_t     body;

    always_comb begin
        body         = '0;
        body.pc      = i_ret_pc;
        body.instr   = i_ret_instr;
        body.rd_we   = i_ret_rd_we;
        body.rd      = i_ret_rd;
        body.rd_data = i_ret_rd_data;
`ifdef RV_TRACE_MEM_EN
        body.mem_we   = i_ret_mem_we;
        body.mem_re   = i_ret_mem_re;
        body.mem_sel  = i_ret_mem_sel;
        body.mem_addr = i_ret_mem_addr;
        body.mem_data = i_ret_mem_data;
`endif
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_left_d = post_left_q;
        wrapped_d   = wrapped_q;
        rd_valid_d  = rd_valid_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = rd_ptr_q;
        trig_hit    = i_trig | (i_trig_pc_en & i_ret_valid & (i_ret_pc == i_trig_pc));
        handshake   = rd_valid_q & i_rd_ready;

        if (i_arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            rd_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    if (i_ret_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q == CNT_FULL) begin
                            wrapped_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (state_q == ST_ARMED) begin
                        if (trig_hit) begin
                            post_left_d = i_post_cnt;
                            state_d     = (i_ret_valid && (i_post_cnt == '0)) ? ST_DONE : ST_POST;
                        end
                    end else if (i_ret_valid) begin
                        // post_left can be 0 here only if the trigger cycle had no
                        // retire; the next record then closes the capture.
                        if (post_left_q <= PL_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            post_left_d = post_left_q - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // When full, count's low bits are zero and this lands on wr_ptr.
                    rd_ptr_d = wr_ptr_q - count_q[AW-1:0];
                    state_d  = (count_q == '0) ? ST_IDLE : ST_DUMP;
                end
                ST_DUMP: begin
                    if (handshake) begin
                        count_d  = count_q - 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        rd_addr  = rd_ptr_q + 1'b1;
                        if (count_q == CNT_ONE) begin
                            state_d    = ST_IDLE;
                            rd_valid_d = 1'b0;
                        end else begin
                            rd_en = 1'b1;
                        end
                    end else if (!rd_valid_q) begin
                        rd_en      = 1'b1;
                        rd_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_left_q <= '0;
            wrapped_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            ts_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_left_q <= post_left_d;
            wrapped_q   <= wrapped_d;
            rd_valid_q  <= rd_valid_d;
            ts_q        <= ts_q + 1'b1;
        end
    end

    rv_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (wr_en),
        .i_waddr  (wr_ptr_q),
        .i_wdata  ({ts_q, body}),
        .i_re     (rd_en),
        .i_raddr  (rd_addr),
        .i_rd_clr (i_reset),
        .o_rdata  (o_rd_data)
    );

    assign o_rd_valid = rd_valid_q;
    assign o_state    = state_q;
    assign o_count    = count_q;
    assign o_wrapped  = wrapped_q;

endmodule

// File: tb/tb_rv_trace_buf.sv
// Directed bench for rv_trace_buf (DEPTH=16, TS_W=16, default build).
module tb_rv_trace_buf;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_ret_valid = 1'b0;
    logic [29:0]   i_ret_pc = '0;
    logic [31:0]   i_ret_instr = '0;
    logic          i_ret_rd_we = 1'b0;
    logic [4:0]    i_ret_rd = '0;
    logic [31:0]   i_ret_rd_data = '0;
    logic          i_arm = 1'b0;
    logic          i_trig = 1'b0;
    logic          i_trig_pc_en = 1'b0;
    logic [29:0]   i_trig_pc = '0;
    logic [3:0]    i_post_cnt = '0;
    logic [115:0]  o_rd_data;
    logic          o_rd_valid;
    logic          i_rd_ready = 1'b0;
    logic [2:0]    o_state;
    logic [4:0]    o_count;
    logic          o_wrapped;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [127:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    rv_trace_buf #(.DEPTH(16), .TS_W(16)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_ret_valid   (i_ret_valid),
        .i_ret_pc      (i_ret_pc),
        .i_ret_instr   (i_ret_instr),
        .i_ret_rd_we   (i_ret_rd_we),
        .i_ret_rd      (i_ret_rd),
        .i_ret_rd_data (i_ret_rd_data),
        .i_arm         (i_arm),
        .i_trig        (i_trig),
        .i_trig_pc_en  (i_trig_pc_en),
        .i_trig_pc     (i_trig_pc),
        .i_post_cnt    (i_post_cnt),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_state       (o_state),
        .o_count       (o_count),
        .o_wrapped     (o_wrapped)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc tracks the DUT timestamp value for the cycle now being driven.
    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic arm();
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
        exp_q.delete();
    endtask

    task automatic retire(input logic [29:0] pc, input logic trig);
        logic [127:0] r;
        i_ret_valid   = 1'b1;
        i_ret_pc      = pc;
        i_ret_instr   = {pc[19:0], 12'h013};
        i_ret_rd_we   = pc[0];
        i_ret_rd      = pc[4:0];
        i_ret_rd_data = {2'b11, ~pc};
        i_trig        = trig;
        r = 128'({16'(cyc), pc, pc[19:0], 12'h013, pc[0], pc[4:0], 2'b11, ~pc});
        if (exp_q.size() == 16) void'(exp_q.pop_front());
        exp_q.push_back(r);
        step();
        i_ret_valid = 1'b0;
        i_trig      = 1'b0;
    endtask

    task automatic drain(input int n, input int start_cnt, input bit to_idle);
        logic [127:0] e;
        i_rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk("beat_valid", 128'(o_rd_valid), 128'(1));
            chk("beat_data", 128'(o_rd_data), e);
            chk("beat_count", 128'(o_count), 128'(start_cnt - i));
            step();
        end
        i_rd_ready = 1'b0;
        if (to_idle) begin
            chk("end_state", 128'(o_state), 128'(0));
            chk("end_valid", 128'(o_rd_valid), 128'(0));
            chk("end_count", 128'(o_count), 128'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step();
        step();
        cyc = 0;
        i_reset = 1'b0;
        chk("rst_state", 128'(o_state), 128'(0));
        chk("rst_count", 128'(o_count), 128'(0));
        chk("rst_wrapped", 128'(o_wrapped), 128'(0));
        chk("rst_valid", 128'(o_rd_valid), 128'(0));
        chk("rst_data", 128'(o_rd_data), 128'(0));

        // 1: trigger on 6th retire with post_cnt=0
        i_post_cnt = 4'd0;
        arm();
        chk("t1_armed", 128'(o_state), 128'(1));
        for (int k = 0; k < 5; k++) retire(30'h40 + 30'(k), 1'b0);
        chk("t1_count5", 128'(o_count), 128'(5));
        retire(30'h45, 1'b1);
        chk("t1_done", 128'(o_state), 128'(3));
        chk("t1_count6", 128'(o_count), 128'(6));
        step();
        chk("t1_dump", 128'(o_state), 128'(4));
        chk("t1_novalid_yet", 128'(o_rd_valid), 128'(0));
        step();
        drain(6, 6, 1'b1);

        // 2: wrap, then external trigger with post_cnt=3
        i_post_cnt = 4'd3;
        arm();
        for (int k = 0; k < 40; k++) retire(30'h400 + 30'(k), 1'b0);
        chk("t2_count_sat", 128'(o_count), 128'(16));
        chk("t2_wrapped", 128'(o_wrapped), 128'(1));
        i_trig = 1'b1;
        step();
        i_trig = 1'b0;
        chk("t2_post", 128'(o_state), 128'(2));
        retire(30'h428, 1'b0);
        retire(30'h429, 1'b0);
        chk("t2_still_post", 128'(o_state), 128'(2));
        retire(30'h42A, 1'b0);
        chk("t2_done", 128'(o_state), 128'(3));
        step();
        step();
        drain(16, 16, 1'b1);
        chk("t2_wrapped_kept", 128'(o_wrapped), 128'(1));

        // 3 + 4: PC trigger at record 7, post_cnt=2, then stall the stream
        i_trig_pc_en = 1'b1;
        i_trig_pc    = 30'h80;
        i_post_cnt   = 4'd2;
        arm();
        chk("t3_wrap_clr", 128'(o_wrapped), 128'(0));
        for (int k = 0; k < 6; k++) retire(30'h7A + 30'(k), 1'b0);
        chk("t3_no_trig", 128'(o_state), 128'(1));
        retire(30'h80, 1'b0);
        chk("t3_post", 128'(o_state), 128'(2));
        retire(30'h81, 1'b0);
        chk("t3_post2", 128'(o_state), 128'(2));
        retire(30'h82, 1'b0);
        chk("t3_done", 128'(o_state), 128'(3));
        chk("t3_count9", 128'(o_count), 128'(9));
        i_trig_pc_en = 1'b0;
        step();
        step();
        for (int s = 0; s < 5; s++) begin
            chk("t4_stall_valid", 128'(o_rd_valid), 128'(1));
            chk("t4_stall_data", 128'(o_rd_data), exp_q[0]);
            chk("t4_stall_count", 128'(o_count), 128'(9));
            step();
        end
        drain(6, 9, 1'b0);
        chk("t3_beat7_pc", 128'(o_rd_data[99:70]), 128'(30'h80));
        drain(3, 3, 1'b1);

        // 5: reset in the middle of a dump
        i_post_cnt = 4'd0;
        arm();
        for (int k = 0; k < 19; k++) retire(30'h600 + 30'(k), 1'b0);
        retire(30'h613, 1'b1);
        chk("t5_done", 128'(o_state), 128'(3));
        chk("t5_wrapped", 128'(o_wrapped), 128'(1));
        step();
        step();
        drain(8, 16, 1'b0);
        chk("t5_count8", 128'(o_count), 128'(8));
        i_reset = 1'b1;
        step();
        cyc = 0;
        i_reset = 1'b0;
        chk("t5_state", 128'(o_state), 128'(0));
        chk("t5_valid", 128'(o_rd_valid), 128'(0));
        chk("t5_count", 128'(o_count), 128'(0));
        chk("t5_wrapped_clr", 128'(o_wrapped), 128'(0));
        chk("t5_data", 128'(o_rd_data), 128'(0));

        // 6: arm + trigger + retire in the same cycle while ARMED
        arm();
        for (int k = 0; k < 3; k++) retire(30'h700 + 30'(k), 1'b0);
        chk("t6_count3", 128'(o_count), 128'(3));
        i_arm       = 1'b1;
        i_trig      = 1'b1;
        i_ret_valid = 1'b1;
        i_ret_pc    = 30'h7FF;
        step();
        i_arm       = 1'b0;
        i_trig      = 1'b0;
        i_ret_valid = 1'b0;
        exp_q.delete();
        chk("t6_armed", 128'(o_state), 128'(1));
        chk("t6_count0", 128'(o_count), 128'(0));
        step();
        chk("t6_no_trig", 128'(o_state), 128'(1));
        retire(30'h710, 1'b1);
        chk("t6_done", 128'(o_state), 128'(3));
        chk("t6_count1", 128'(o_count), 128'(1));
        step();
        step();
        drain(1, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
